cpu_fsm_controller: RTL and testbench
=====================================

Name: cpu_fsm_controller

Overview:
- Moore-style sequencer that drives the 16-bit datapath: register file, A/B/C pipeline registers, shifter, ALU and status register.
- Holds the instruction register and decodes it into readnum/writenum, shift, ALUop and the sign-extended immediate.
- Steps each instruction through a fixed sequence of control states.
- Sits between the instruction source (load/in/s) and the datapath control pins; signals completion through w.

Parameters:
- DW, 16, datapath and instruction width; only 16 is supported.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in, input, DW, instruction word.
- load, input, 1, IR load enable.
- s, input, 1, start pulse/level.
- w, output, 1, idle/wait flag; 1 only in WAIT.
- datapath_in, output, DW, sign-extended imm8 to the datapath.
- vsel, output, 1, 1 = write datapath_in; 0 = write datapath_out.
- writenum, output, 3, register file write address.
- write, output, 1, register file write enable.
- readnum, output, 3, register file read address.
- loada, output, 1, A register enable.
- loadb, output, 1, B register enable.
- loadc, output, 1, C register enable.
- loads, output, 1, status register enable.
- asel, output, 1, 1 = force Ain to 0.
- bsel, output, 1, 1 = imm5 path; this controller always drives 0.
- shift, output, 2, shifter op, taken from IR[4:3].
- ALUop, output, 2, ALU op.

Behaviour:
- Asynchronous, active-low reset (reset_n=0) forces: state=WAIT, IR=0.
  - Outputs during reset: w=1, all strobes (write, loada, loadb, loadc, loads) = 0, vsel=0, asel=0, bsel=0.
- IR fields:
  - opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0], imm8 = IR[7:0].
- datapath_in = {{8{imm8[7]}}, imm8} at all times (combinational from IR).
- IR loading: IR <= in on a clk edge when load=1 and state=WAIT. load is ignored in every other state, so the IR stays stable during execution.
- Outputs are a function of state and IR only (Moore). Any output not listed for a state is 0.
- States and transitions:
  - WAIT: w=1. s=1 -> DECODE; otherwise stay. s is ignored outside WAIT.
  - DECODE: no strobes.
    - opcode 110, op 10 -> WRITE_IMM.
    - opcode 110, op 00 -> GET_B.
    - opcode 101 -> GET_A.
    - any other encoding -> WAIT, with no register write.
  - WRITE_IMM: vsel=1, writenum=Rn, write=1 -> WAIT.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> COMPUTE.
  - COMPUTE: shift=sh.
    - MOV register form: asel=1, ALUop=00, loadc=1 -> WRITE_REG.
    - ALU ops: asel=0, ALUop=op.
      - CMP (op=01): loads=1, loadc=0 -> WAIT.
      - Others: loadc=1 -> WRITE_REG.
  - WRITE_REG: vsel=0, writenum=Rd, write=1 -> WAIT.
- readnum defaults to Rm and writenum defaults to Rd in states that do not specify them. This keeps them stable.
- Busy time (w=0), counted from the edge that samples s=1:
  - MOV imm: 2 cycles.
  - MOV register: 4 cycles.
  - CMP: 4 cycles.
  - ADD/AND/MVN: 5 cycles.
  - Undefined encoding: 1 cycle.
- Back-to-back operation: if s is held at 1, the next instruction starts on the first WAIT cycle.
- Reset asserted mid-instruction aborts immediately. No further strobes are issued. Partially loaded A/B/C contents are not cleaned up.

Optional Feature:
- Macro: CPU_FSM_DBG_STATE_EN.
- When defined: adds output port state_dbg (3 bits) carrying the encoded current state. Reset value is the WAIT encoding (000).
- When undefined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - State encodings: WAIT=000, DECODE=001, WRITE_IMM=010, GET_A=011, GET_B=100, COMPUTE=101, WRITE_REG=110.
  - Opcode constants: OPC_MOV=110, OPC_ALU=101.
  - ALUop constants: ADD=00, CMP=01, AND=10, MVN=11.
  - Field-index constants.
- One natural sub-module: instr_decoder. It is combinational, mapping IR to Rn/Rd/Rm/sh/op/opcode/sign-extended imm8.

Test Plan:
- MOV R0,#7:
  - Stimulus: load in=0xD007 in WAIT, then pulse s.
  - Required: DECODE, then WRITE_IMM with vsel=1, writenum=0, write=1, datapath_in=0x0007; w=1 two cycles after s is sampled.
- MOV R3,#-1:
  - Stimulus: in=0xD3FF.
  - Required: datapath_in=0xFFFF, writenum=3, write=1 in WRITE_IMM only.
- ADD R2,R1,R0,LSL#1:
  - Stimulus: in=0xA148.
  - Required: GET_A readnum=1 loada=1; GET_B readnum=0 loadb=1; COMPUTE shift=01 ALUop=00 asel=0 loadc=1; WRITE_REG writenum=2 write=1; w low for exactly 5 cycles.
- CMP R1,R0:
  - Stimulus: in=0xA900.
  - Required: COMPUTE ALUop=01 loads=1 loadc=0; no write pulse in any cycle; return to WAIT after 4 cycles.
- Undefined opcode and load while busy:
  - Stimulus 1: in=0x0000 with s.
  - Required: DECODE, then WAIT with zero strobes.
  - Stimulus 2: load=1 with in=0xD0AA while an ADD is executing.
  - Required: IR unchanged, ADD completes correctly.
- Reset mid-op:
  - Stimulus: reset_n=0 asserted asynchronously during GET_B of an ADD.
  - Required: immediately w=1, all strobes 0, IR=0; after release, the FSM idles in WAIT until s.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared definitions for the CPU control sequencer. Holds the
//                state encoding, opcode and ALU-op constants, the instruction
//                field positions and a sign-extension helper.
//                Consumers: instr_decoder, cpu_fsm_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Encodings are fixed because they are visible on the optional debug port.
    typedef enum logic [2:0] {
        ST_WAIT      = 3'b000,
        ST_DECODE    = 3'b001,
        ST_WRITE_IMM = 3'b010,
        ST_GET_A     = 3'b011,
        ST_GET_B     = 3'b100,
        ST_COMPUTE   = 3'b101,
        ST_WRITE_REG = 3'b110
    } state_t;

    // Opcodes (IR[15:13])
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // MOV sub-ops (IR[12:11] when opcode is OPC_MOV)
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;

    // ALU ops (IR[12:11] when opcode is OPC_ALU)
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    // Instruction field positions
    localparam int IR_OPC_HI = 15;
    localparam int IR_OPC_LO = 13;
    localparam int IR_OP_HI  = 12;
    localparam int IR_OP_LO  = 11;
    localparam int IR_RN_HI  = 10;
    localparam int IR_RN_LO  = 8;
    localparam int IR_RD_HI  = 7;
    localparam int IR_RD_LO  = 5;
    localparam int IR_SH_HI  = 4;
    localparam int IR_SH_LO  = 3;
    localparam int IR_RM_HI  = 2;
    localparam int IR_RM_LO  = 0;
    localparam int IR_IMM_HI = 7;

    function automatic logic [15:0] sign_ext8(input logic [7:0] imm);
        return {{8{imm[7]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decoder
//  Description : Purely combinational split of the instruction register into
//                its fields plus the sign-extended 8-bit immediate.
//  Ports       : i_ir        - instruction register contents
//                o_opcode    - IR[15:13]
//                o_op        - IR[12:11]
//                o_rn/o_rd/o_rm - register specifiers
//                o_sh        - shifter op IR[4:3]
//                o_imm_sext  - {{8{imm8[7]}}, imm8}
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_ir,
    output logic [2:0]    o_opcode,
    output logic [1:0]    o_op,
    output logic [2:0]    o_rn,
    output logic [2:0]    o_rd,
    output logic [1:0]    o_sh,
    output logic [2:0]    o_rm,
    output logic [DW-1:0] o_imm_sext
);

    assign o_opcode   = i_ir[IR_OPC_HI:IR_OPC_LO];
    assign o_op       = i_ir[IR_OP_HI:IR_OP_LO];
    assign o_rn       = i_ir[IR_RN_HI:IR_RN_LO];
    assign o_rd       = i_ir[IR_RD_HI:IR_RD_LO];
    assign o_sh       = i_ir[IR_SH_HI:IR_SH_LO];
    assign o_rm       = i_ir[IR_RM_HI:IR_RM_LO];
    assign o_imm_sext = sign_ext8(i_ir[IR_IMM_HI:0]);

endmodule
`default_nettype wire

// File: rtl/cpu_fsm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_fsm_controller
//  Description : Moore sequencer for the 16-bit datapath. Holds the
//                instruction register, decodes it and walks each instruction
//                through a fixed series of control states.
//  Ports       : clk, reset_n (async, active low)
//                in / load      - instruction word and IR load (WAIT only)
//                s              - start; sampled only in WAIT
//                w              - 1 only while idle in WAIT
//                datapath_in    - sign-extended imm8
//                vsel, writenum, write, readnum      - register file control
//                loada, loadb, loadc, loads          - A/B/C/status enables
//                asel, bsel, shift, ALUop            - operand/shift/ALU select
//                state_dbg      - encoded state (CPU_FSM_DBG_STATE_EN only)
//  Options     : `define CPU_FSM_DBG_STATE_EN adds the state_dbg output.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_fsm_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] in,
    input  logic          load,
    input  logic          s,
    output logic          w,
    output logic [DW-1:0] datapath_in,
    output logic          vsel,
    output logic [2:0]    writenum,
    output logic          write,
    output logic [2:0]    readnum,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop
`ifdef CPU_FSM_DBG_STATE_EN
    ,
    output logic [2:0]    state_dbg
`endif
);

    state_t        r_state;
    state_t        w_next_state;
    logic [DW-1:0] r_ir;

    logic [2:0]    w_opcode;
    logic [1:0]    w_op;
    logic [2:0]    w_rn;
    logic [2:0]    w_rd;
    logic [1:0]    w_sh;
    logic [2:0]    w_rm;

    instr_decoder #(
        .DW (DW)
    ) u_instr_decoder (
        .i_ir       (r_ir),
        .o_opcode   (w_opcode),
        .o_op       (w_op),
        .o_rn       (w_rn),
        .o_rd       (w_rd),
        .o_sh       (w_sh),
        .o_rm       (w_rm),
        .o_imm_sext (datapath_in)
    );

    // The IR only accepts a new word while idle so it stays stable for the
    // whole of an instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= '0;
        end else if (load && (r_state == ST_WAIT)) begin
            r_ir <= in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs depend only on state and IR. readnum/writenum idle at Rm/Rd so
    // the register-file addresses do not toggle outside their own states.
    always_comb begin
        w_next_state = r_state;
        w            = 1'b0;
        vsel         = 1'b0;
        writenum     = w_rd;
        write        = 1'b0;
        readnum      = w_rm;
        loada        = 1'b0;
        loadb        = 1'b0;
        loadc        = 1'b0;
        loads        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        shift        = 2'b00;
        ALUop        = 2'b00;

        case (r_state)
            ST_WAIT: begin
                w = 1'b1;
                if (s) begin
                    w_next_state = ST_DECODE;
                end
            end

            ST_DECODE: begin
                if ((w_opcode == OPC_MOV) && (w_op == OP_MOV_IMM)) begin
                    w_next_state = ST_WRITE_IMM;
                end else if ((w_opcode == OPC_MOV) && (w_op == OP_MOV_REG)) begin
                    w_next_state = ST_GET_B;
                end else if (w_opcode == OPC_ALU) begin
                    w_next_state = ST_GET_A;
                end else begin
                    // Unrecognised encoding: retire with no side effects.
                    w_next_state = ST_WAIT;
                end
            end

            ST_WRITE_IMM: begin
                vsel         = 1'b1;
                writenum     = w_rn;
                write        = 1'b1;
                w_next_state = ST_WAIT;
            end

            ST_GET_A: begin
                readnum      = w_rn;
                loada        = 1'b1;
                w_next_state = ST_GET_B;
            end

            ST_GET_B: begin
                readnum      = w_rm;
                loadb        = 1'b1;
                w_next_state = ST_COMPUTE;
            end

            ST_COMPUTE: begin
                shift = w_sh;
                if (w_opcode == OPC_MOV) begin
                    // MOV Rd,Rm: 0 + shifted B through the adder.
                    asel         = 1'b1;
                    ALUop        = ALU_ADD;
                    loadc        = 1'b1;
                    w_next_state = ST_WRITE_REG;
                end else if (w_op == ALU_CMP) begin
                    ALUop        = w_op;
                    loads        = 1'b1;
                    w_next_state = ST_WAIT;
                end else begin
                    ALUop        = w_op;
                    loadc        = 1'b1;
                    w_next_state = ST_WRITE_REG;
                end
            end

            ST_WRITE_REG: begin
                vsel         = 1'b0;
                writenum     = w_rd;
                write        = 1'b1;
                w_next_state = ST_WAIT;
            end

            default: begin
                w_next_state = ST_WAIT;
            end
        endcase
    end

`ifdef CPU_FSM_DBG_STATE_EN
    assign state_dbg = r_state;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_fsm_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_fsm_controller
//  Description : Self-checking bench for cpu_fsm_controller. A reference
//                model pushes the expected per-cycle output vector for each
//                instruction into a queue; each scenario task pops and
//                compares against the DUT one cycle at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_fsm_controller;

    typedef struct packed {
        logic        w;
        logic        vsel;
        logic [2:0]  writenum;
        logic        write;
        logic [2:0]  readnum;
        logic        loada;
        logic        loadb;
        logic        loadc;
        logic        loads;
        logic        asel;
        logic        bsel;
        logic [1:0]  shift;
        logic [1:0]  aluop;
        logic [15:0] dpin;
    } outv_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] in_word;
    logic        load;
    logic        s;
    logic        w;
    logic [15:0] datapath_in;
    logic        vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum;
    logic        loada, loadb, loadc, loads;
    logic        asel, bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
`ifdef CPU_FSM_DBG_STATE_EN
    logic [2:0]  state_dbg;
`endif

    int    n_checks = 0;
    int    n_errors = 0;
    outv_t exp_q[$];

    cpu_fsm_controller #(
        .DW (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in_word),
        .load        (load),
        .s           (s),
        .w           (w),
        .datapath_in (datapath_in),
        .vsel        (vsel),
        .writenum    (writenum),
        .write       (write),
        .readnum     (readnum),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .asel        (asel),
        .bsel        (bsel),
        .shift       (shift),
        .ALUop       (aluop)
`ifdef CPU_FSM_DBG_STATE_EN
        ,
        .state_dbg   (state_dbg)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic outv_t observe();
        outv_t v;
        v.w = w; v.vsel = vsel; v.writenum = writenum; v.write = write;
        v.readnum = readnum; v.loada = loada; v.loadb = loadb; v.loadc = loadc;
        v.loads = loads; v.asel = asel; v.bsel = bsel; v.shift = shift;
        v.aluop = aluop; v.dpin = datapath_in;
        return v;
    endfunction

    // Reference model: expected output vector for every cycle from DECODE
    // up to and including the first WAIT cycle after the instruction.
    function automatic void model_push(input logic [15:0] ir);
        logic [2:0] opc; logic [1:0] op; outv_t base; outv_t v;
        opc = ir[15:13];
        op  = ir[12:11];
        base = '0;
        base.readnum  = ir[2:0];
        base.writenum = ir[7:5];
        base.dpin     = {{8{ir[7]}}, ir[7:0]};
        exp_q.push_back(base);                                  // DECODE
        if (opc == 3'b110 && op == 2'b10) begin
            v = base; v.vsel = 1'b1; v.writenum = ir[10:8]; v.write = 1'b1;
            exp_q.push_back(v);                                 // WRITE_IMM
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            if (opc == 3'b101) begin
                v = base; v.readnum = ir[10:8]; v.loada = 1'b1;
                exp_q.push_back(v);                             // GET_A
            end
            v = base; v.loadb = 1'b1;
            exp_q.push_back(v);                                 // GET_B
            v = base; v.shift = ir[4:3];
            if (opc == 3'b110) begin
                v.asel = 1'b1; v.loadc = 1'b1;
            end else begin
                v.aluop = op;
                if (op == 2'b01) v.loads = 1'b1;
                else             v.loadc = 1'b1;
            end
            exp_q.push_back(v);                                 // COMPUTE
            if (!(opc == 3'b101 && op == 2'b01)) begin
                v = base; v.write = 1'b1;
                exp_q.push_back(v);                             // WRITE_REG
            end
        end
        v = base; v.w = 1'b1;
        exp_q.push_back(v);                                     // WAIT
    endfunction

    task automatic load_instr(input logic [15:0] ir);
        @(negedge clk); in_word = ir; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    // Leaves the bench at posedge+1 with the DUT in DECODE.
    task automatic start_instr();
        @(negedge clk); s = 1'b1;
        @(posedge clk); #1; s = 1'b0;
    endtask

    task automatic test_reset();
        outv_t g; outv_t e;
        reset_n = 1'b0; load = 1'b0; s = 1'b0; in_word = 16'hFFFF;
        repeat (3) @(posedge clk);
        #1;
        e = '0; e.w = 1'b1;
        g = observe();
        n_checks++;
        if (g !== e) begin
            n_errors++;
            $display("FAIL reset_state: got %h required %h", g, e);
        end
`ifdef CPU_FSM_DBG_STATE_EN
        n_checks++;
        if (state_dbg !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_state_dbg: got %b required 000", state_dbg);
        end
`endif
        @(negedge clk); reset_n = 1'b1;
        // s low: must stay idle.
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (w !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_after_reset: w got %b required 1", w);
        end
    endtask

    task automatic test_instr(input string name, input logic [15:0] ir, input int busy_req);
        outv_t g; outv_t e; int busy; int cyc;
        load_instr(ir);
        start_instr();
        model_push(ir);
        busy = 0; cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = observe();
            if (g.w !== 1'b1) busy++;
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL %s cyc%0d: got %h required %h", name, cyc, g, e);
            end
            cyc++;
            if (exp_q.size() > 0) begin @(posedge clk); #1; end
        end
        n_checks++;
        if (busy !== busy_req) begin
            n_errors++;
            $display("FAIL %s_busy: got %0d cycles required %0d", name, busy, busy_req);
        end
    endtask

    task automatic test_load_while_busy();
        outv_t g; outv_t e; int cyc;
        load_instr(16'hA148);
        start_instr();
        in_word = 16'hD0AA; load = 1'b1;
        model_push(16'hA148);
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL load_busy cyc%0d: got %h required %h", cyc, g, e);
            end
            cyc++;
            if (exp_q.size() > 0) begin @(posedge clk); #1; end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        outv_t g; outv_t e; int cyc;
        load_instr(16'hD1F0);
        @(negedge clk); s = 1'b1;
        @(posedge clk); #1;
        model_push(16'hD1F0);
        model_push(16'hD1F0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL back_to_back cyc%0d: got %h required %h", cyc, g, e);
            end
            cyc++;
            if (exp_q.size() > 0) begin @(posedge clk); #1; end
        end
        s = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        outv_t g; outv_t e;
        load_instr(16'hA148);
        start_instr();                       // DECODE
        @(posedge clk); #1;                  // GET_A
        @(posedge clk); #1;                  // GET_B
        n_checks++;
        if (loadb !== 1'b1 || readnum !== 3'd0) begin
            n_errors++;
            $display("FAIL mid_get_b: got loadb=%b readnum=%0d required loadb=1 readnum=0", loadb, readnum);
        end
        #2; reset_n = 1'b0; #1;
        e = '0; e.w = 1'b1;
        g = observe();
        n_checks++;
        if (g !== e) begin
            n_errors++;
            $display("FAIL mid_reset: got %h required %h", g, e);
        end
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL post_reset_idle%0d: got %h required %h", i, g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_instr("mov_r0_7",   16'hD007, 2);
        test_instr("mov_r3_m1",  16'hD3FF, 2);
        test_instr("add_lsl1",   16'hA148, 5);
        test_instr("cmp_r1_r0",  16'hA900, 4);
        test_instr("and_op",     16'hB5A5, 5);
        test_instr("mvn_op",     16'hB8F3, 5);
        test_instr("mov_reg",    16'hC05A, 4);
        test_instr("undefined",  16'h0000, 1);
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_instr("mov_after",  16'hD280, 2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
